mult_sequencer: RTL

Shift-and-add multiply controller that sequences the shared WIDTH-bit adder datapath. It accepts two unsigned operands on a start strobe and iterates the adder once per bit of the multiplier. It then presents a 2*WIDTH-bit product with a one-cycle done pulse. It sits between the io_in/io_out top-level wrapper and the adder instance, which it drives through a dedicated adder port.

---
 rtl/mult_sequencer_pkg.sv | 21 ++
 rtl/mult_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer: FSM states,
// operand width bounds and counter sizing.
package mult_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    localparam int CNT_W_MAX = $clog2(WIDTH_MAX + 1);

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sequencer.sv
// Shift-and-add multiply controller driving an external WIDTH-bit adder.
// Optional feature: define MULT_ZERO_BYPASS_EN to skip RUN when an operand is zero.
import mult_sequencer_pkg::*;

module mult_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_c,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_sh, lo_sh;
    logic             zero_op;

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Adder operands are kept out of the FSM block: add_s feeds back combinationally.
    assign add_a = (state_q == ST_RUN) ? hi_q : '0;
    assign add_b = (state_q == ST_RUN && lo_q[0]) ? mcand_q : '0;

    // {hi,lo} <= {carry, sum, lo[W-1:1]}; WIDTH==1 has no lo[W-1:1] slice.
    if (WIDTH == 1) begin : g_w1
        assign hi_sh = add_c;
        assign lo_sh = add_s;
    end else begin : g_wn
        assign hi_sh = {add_c, add_s[WIDTH-1:1]};
        assign lo_sh = {add_s[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (zero_op) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = ST_DONE;
                    end else begin
                        mcand_d = a;
                        hi_d    = '0;
                        lo_d    = b;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                hi_d  = hi_sh;
                lo_d  = lo_sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = {hi_q, lo_q};

endmodule
